// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls from ID, instruction memory
// link, and the IF/ID pipeline register outputs.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 16
);

  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_offset;
  logic                   jump;
  logic [11:0]            jump_target;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic [PC_WIDTH-1:0]    id_pc_plus1;
  logic                   id_valid;
  logic                   halted;

  // Environment side: pipeline control and instruction memory.
  modport master (
    output stall,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_target,
    output instruction,
    input  pc,
    input  id_instr,
    input  id_pc_plus1,
    input  id_valid,
    input  halted
  );

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_target,
    input  instruction,
    output pc,
    output id_instr,
    output id_pc_plus1,
    output id_valid,
    output halted
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, and handles
// stall, branch/jump redirect with a one-bubble flush, and HALT detection.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0]    id_pc_plus1_q, id_pc_plus1_d;
  logic                   id_valid_q, id_valid_d;

  logic [PC_WIDTH-1:0]    pc_plus1;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    jump_dest;
  logic                   is_halt;

  assign pc_plus1      = pc_q + PC_WIDTH'(1);
  assign branch_target = id_pc_plus1_q + bus.branch_offset;
  // Jumps keep the region bits of the instruction that issued them.
  assign jump_dest     = {id_pc_plus1_q[PC_WIDTH-1:12], bus.jump_target};
  assign is_halt       = (bus.instruction[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus1_d = id_pc_plus1_q;
    id_valid_d    = id_valid_q;

    unique case (state_q)
      StRun: begin
        if (bus.jump) begin
          pc_d       = jump_dest;
          id_valid_d = 1'b0;
        end else if (bus.branch_taken) begin
          pc_d       = branch_target;
          id_valid_d = 1'b0;
        end else if (!bus.stall) begin
          id_instr_d    = bus.instruction;
          id_pc_plus1_d = pc_plus1;
          id_valid_d    = 1'b1;
          // HALT still enters IF/ID, but the PC parks on its address.
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_plus1;
          end
        end
      end
      StHalted: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc_plus1_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus1 = id_pc_plus1_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.halted      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected IF state
// into a scoreboard as each step is driven; results are popped after the edge.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  assign bus.instruction = mem[bus.pc[7:0]];

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [15:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_halt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk({e.tag, ".pc"}, bus.pc, e.pc);
    chk({e.tag, ".id_instr"}, bus.id_instr, e.instr);
    chk({e.tag, ".id_pc_plus1"}, bus.id_pc_plus1, e.pc1);
    chk({e.tag, ".id_valid"}, {15'd0, bus.id_valid}, {15'd0, e.valid});
    chk({e.tag, ".halted"}, {15'd0, bus.halted}, {15'd0, e.halted});
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_instr = 16'h0000;
    m_pc1   = 16'h0000;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".pc"}, bus.pc, 16'h0000);
    chk({tag, ".id_instr"}, bus.id_instr, 16'h0000);
    chk({tag, ".id_pc_plus1"}, bus.id_pc_plus1, 16'h0000);
    chk({tag, ".id_valid"}, {15'd0, bus.id_valid}, 16'h0000);
    chk({tag, ".halted"}, {15'd0, bus.halted}, 16'h0000);
  endtask

  // One clock: drive controls, predict, push, clock, pop and compare.
  task automatic step(input string tag, input logic st, input logic br, input logic jp,
                      input logic [15:0] off, input logic [11:0] jt);
    exp_t        e;
    logic [15:0] ins;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.jump          = jp;
    bus.branch_offset = off;
    bus.jump_target   = jt;
    ins = mem[m_pc[7:0]];
    if (m_halt) begin
      m_valid = 1'b0;
    end else if (jp) begin
      m_pc    = {m_pc1[15:12], jt};
      m_valid = 1'b0;
    end else if (br) begin
      m_pc    = m_pc1 + off;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = ins;
      m_pc1   = m_pc + 16'd1;
      m_valid = 1'b1;
      if (ins[15:12] == 4'hF) m_halt = 1'b1;
      else                    m_pc   = m_pc + 16'd1;
    end
    e.tag    = tag;
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.pc1    = m_pc1;
    e.valid  = m_valid;
    e.halted = m_halt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.jump          = 1'b0;
    bus.branch_offset = 16'h0000;
    bus.jump_target   = 12'h000;
    model_reset();

    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b0;

    // Sequential fetch up to pc = 3, then stall there.
    for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("seq_pc3", bus.pc, 16'h0003);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("stall_pc", bus.pc, 16'h0003);
    chk("stall_instr", bus.id_instr, 16'h1002);
    step("post_stall", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("post_stall_pc", bus.pc, 16'h0004);
    chk("post_stall_instr", bus.id_instr, 16'h1003);
    step("seq5", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("seq5_pc1", bus.id_pc_plus1, 16'h0005);

    // Backward branch: 5 + (-4) = 1, one bubble.
    step("branch", 1'b0, 1'b1, 1'b0, 16'hFFFC, 12'h0);
    chk("branch_pc", bus.pc, 16'h0001);
    step("after_branch", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);

    // Move into region 3 so the jump keeps id_pc_plus1[15:12] = 3.
    step("br_3004", 1'b0, 1'b1, 1'b0, 16'h3002, 12'h0);
    step("fetch_3004", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("pc1_3005", bus.id_pc_plus1, 16'h3005);
    step("jump", 1'b0, 1'b0, 1'b1, 16'h0, 12'h0A0);
    chk("jump_pc", bus.pc, 16'h30A0);
    step("jump_br_stall", 1'b1, 1'b1, 1'b1, 16'h0001, 12'h0B0);
    chk("jump_wins_pc", bus.pc, 16'h30B0);

    // Wrap-around: reach region F, jump to FFFF, then fetch across zero.
    step("br_f000", 1'b0, 1'b1, 1'b0, 16'hBFFB, 12'h0);
    step("fetch_f000", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    step("jump_ffff", 1'b0, 1'b0, 1'b1, 16'h0, 12'hFFF);
    chk("wrap_pre_pc", bus.pc, 16'hFFFF);
    step("wrap", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("wrap_pc", bus.pc, 16'h0000);
    chk("wrap_pc1", bus.id_pc_plus1, 16'h0000);

    // Reset between edges while pc = 7.
    for (int i = 0; i < 7; i++) step("seq7", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("seq7_pc", bus.pc, 16'h0007);
    async_reset("reset_mid");

    // HALT at address 4; a stalled HALT is not acted upon.
    mem[4] = 16'hF000;
    for (int i = 0; i < 4; i++) step("pre_halt", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    step("halt_stalled", 1'b1, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("halt_stalled_h", {15'd0, bus.halted}, 16'h0000);
    step("halt", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("halt_h", {15'd0, bus.halted}, 16'h0001);
    chk("halt_instr", bus.id_instr, 16'hF000);
    chk("halt_pc", bus.pc, 16'h0004);
    for (int i = 0; i < 10; i++) begin
      step("halted", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom));
      chk("halted_pc", bus.pc, 16'h0004);
    end
    async_reset("reset_halted");
    mem[4] = 16'h1004;
    step("restart", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    step("restart", 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    chk("restart_pc", bus.pc, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
